dmem_arbiter: RTL

Two-port arbiter and access sequencer in front of the byte-addressed data memory. Shares the memory between the core load/store path (port C) and the debug/loader path (port D) with round-robin priority. Rejects misaligned, out-of-range and illegal-size accesses before they reach the memory. Returns load data and status through a registered one-cycle response.

---
 rtl/dmem_arbiter_if.sv | 46 ++++
 rtl/dmem_arbiter.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - requester (C, D) and memory-side signals of the data memory arbiter
interface dmem_arbiter_if;
    logic        C_Req;
    logic        C_RW;
    logic [2:0]  C_Size;
    logic [31:0] C_Addr;
    logic [31:0] C_DataW;
    logic        C_Ack;
    logic        C_Done;
    logic        C_Err;
    logic [31:0] C_DataR;

    logic        D_Req;
    logic        D_RW;
    logic [2:0]  D_Size;
    logic [31:0] D_Addr;
    logic [31:0] D_DataW;
    logic        D_Ack;
    logic        D_Done;
    logic        D_Err;
    logic [31:0] D_DataR;

    logic        MemRW;
    logic [2:0]  Size;
    logic [31:0] Addr;
    logic [31:0] DataW;
    logic [31:0] DataR;

    modport slave (
        input  C_Req, C_RW, C_Size, C_Addr, C_DataW,
        output C_Ack, C_Done, C_Err, C_DataR,
        input  D_Req, D_RW, D_Size, D_Addr, D_DataW,
        output D_Ack, D_Done, D_Err, D_DataR,
        output MemRW, Size, Addr, DataW,
        input  DataR
    );

    modport master (
        output C_Req, C_RW, C_Size, C_Addr, C_DataW,
        input  C_Ack, C_Done, C_Err, C_DataR,
        output D_Req, D_RW, D_Size, D_Addr, D_DataW,
        input  D_Ack, D_Done, D_Err, D_DataR,
        input  MemRW, Size, Addr, DataW,
        output DataR
    );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin two-port arbiter and access sequencer for the data memory
module dmem_arbiter #(
    parameter int unsigned MEM_BYTES = 128
) (
    input  logic          clk,
    input  logic          rst_n,
    dmem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        prio;
    logic        cmd_rw;
    logic [2:0]  cmd_size;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_dataw;
    logic        cmd_owner;
    logic        cmd_err;
    logic [31:0] resp_data;

    logic        grant_c;
    logic        grant_d;
    logic        sel_rw;
    logic [2:0]  sel_size;
    logic [31:0] sel_addr;
    logic [31:0] sel_dataw;
    logic        sel_err;

    // Last byte touched is formed in 33 bits so addresses near 2^32 cannot wrap into range.
    function automatic logic access_err(input logic rw, input logic [2:0] size, input logic [31:0] addr);
        logic [32:0] last;
        logic        err;
        err  = 1'b0;
        last = {1'b0, addr};
        case (size[1:0])
            2'b00: last = {1'b0, addr};
            2'b01: begin
                last = {1'b0, addr} + 33'd1;
                if (addr[0]) err = 1'b1;
            end
            2'b10: begin
                last = {1'b0, addr} + 33'd3;
                if (addr[1:0] != 2'b00) err = 1'b1;
            end
            default: err = 1'b1;
        endcase
        if (rw && size[2]) err = 1'b1;
        if (last >= 33'(MEM_BYTES)) err = 1'b1;
        return err;
    endfunction

    function automatic logic [31:0] extend_load(input logic [31:0] d, input logic [2:0] size);
        logic [31:0] r;
        case (size)
            3'b000:  r = {24'd0, d[7:0]};
            3'b100:  r = {{24{d[7]}}, d[7:0]};
            3'b001:  r = {16'd0, d[15:0]};
            3'b101:  r = {{16{d[15]}}, d[15:0]};
            default: r = d;
        endcase
        return r;
    endfunction

    always_comb begin
        grant_c = 1'b0;
        grant_d = 1'b0;
        if (rst_n && state == IDLE) begin
            grant_c = bus.C_Req && (!bus.D_Req || !prio);
            grant_d = bus.D_Req && (!bus.C_Req || prio);
        end
    end

    always_comb begin
        sel_rw    = grant_d ? bus.D_RW    : bus.C_RW;
        sel_size  = grant_d ? bus.D_Size  : bus.C_Size;
        sel_addr  = grant_d ? bus.D_Addr  : bus.C_Addr;
        sel_dataw = grant_d ? bus.D_DataW : bus.C_DataW;
        sel_err   = access_err(sel_rw, sel_size, sel_addr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Memory and response outputs depend only on registered state, never on a Req.
    always_comb begin
        state_next  = state;
        bus.C_Ack   = grant_c;
        bus.D_Ack   = grant_d;
        bus.MemRW   = 1'b0;
        bus.Size    = 3'd0;
        bus.Addr    = 32'd0;
        bus.DataW   = 32'd0;
        bus.C_Done  = 1'b0;
        bus.C_Err   = 1'b0;
        bus.C_DataR = 32'd0;
        bus.D_Done  = 1'b0;
        bus.D_Err   = 1'b0;
        bus.D_DataR = 32'd0;
        case (state)
            IDLE: begin
                if (grant_c || grant_d) begin
                    state_next = sel_err ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                state_next = RESP;
                bus.MemRW  = cmd_rw;
                bus.Size   = cmd_size;
                bus.Addr   = cmd_addr;
                bus.DataW  = cmd_dataw;
            end
            RESP: begin
                state_next = IDLE;
                if (cmd_owner) begin
                    bus.D_Done  = 1'b1;
                    bus.D_Err   = cmd_err;
                    bus.D_DataR = resp_data;
                end else begin
                    bus.C_Done  = 1'b1;
                    bus.C_Err   = cmd_err;
                    bus.C_DataR = resp_data;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio      <= 1'b0;
            cmd_rw    <= 1'b0;
            cmd_size  <= 3'd0;
            cmd_addr  <= 32'd0;
            cmd_dataw <= 32'd0;
            cmd_owner <= 1'b0;
            cmd_err   <= 1'b0;
            resp_data <= 32'd0;
        end else if (grant_c || grant_d) begin
            prio      <= grant_c;
            cmd_rw    <= sel_rw;
            cmd_size  <= sel_size;
            cmd_addr  <= sel_addr;
            cmd_dataw <= sel_dataw;
            cmd_owner <= grant_d;
            cmd_err   <= sel_err;
            resp_data <= 32'd0;
        end else if (state == ACCESS) begin
            resp_data <= cmd_rw ? 32'd0 : extend_load(bus.DataR, cmd_size);
        end
    end
endmodule
